// File: rtl/vga_timing_pkg.sv
// Shared timing definitions for the VGA raster generator: per-axis timing sets
// for the standard modes and the total-period helper.
package vga_timing_pkg;

  typedef struct packed {
    int active;
    int fp;
    int sync;
    int bp;
    bit pol;
  } axis_timing_t;

  // 640x480@60 (25.175 MHz nominal, negative syncs)
  localparam axis_timing_t VGA640_H = '{active: 640, fp: 16, sync: 96,  bp: 48, pol: 1'b0};
  localparam axis_timing_t VGA640_V = '{active: 480, fp: 10, sync: 2,   bp: 33, pol: 1'b0};

  // 800x600@60 (40 MHz nominal, positive syncs)
  localparam axis_timing_t VGA800_H = '{active: 800, fp: 40, sync: 128, bp: 88, pol: 1'b1};
  localparam axis_timing_t VGA800_V = '{active: 600, fp: 1,  sync: 4,   bp: 23, pol: 1'b1};

  function automatic int calc_total(int active, int fp, int sync, int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap, plus sync and active decoding
// taken from the next count so every registered output matches the count.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int CNT_W  = 11,
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48,
  parameter bit POL    = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  input  logic             restart,
  output logic [CNT_W-1:0] count,
  output logic             sync,
  output logic             active_next,
  output logic             wrap
);

  localparam int TOTAL = calc_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT_END    = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(ACTIVE + FP + SYNC);

  if (ACTIVE <= 0 || FP <= 0 || SYNC <= 0 || BP <= 0 ||
      longint'(TOTAL) > (longint'(1) << CNT_W)) begin : g_bad_params
    $error("vga_axis_counter: zero timing parameter or CNT_W too narrow for TOTAL");
  end

  logic [CNT_W-1:0] count_next;
  logic             sync_next;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    count_next = count;
    if (restart) begin
      count_next = '0;
    end else if (advance) begin
      count_next = (count == LAST) ? '0 : count + 1'b1;
    end
  end

  assign wrap        = advance && !restart && (count == LAST);
  assign active_next = count_next < ACT_END;
  assign sync_next   = (count_next >= SYNC_START && count_next < SYNC_END) ? POL : ~POL;

  // NOTE: state is updated with <= so every flop samples pre-edge values of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      sync  <= ~POL;
    end else begin
      count <= count_next;
      sync  <= sync_next;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Full-raster VGA timing generator: horizontal and vertical axis counters with
// pixel-clock enable, synchronous restart, active-video flag and line/frame strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int CNT_W    = 11,
  parameter int H_ACTIVE = VGA640_H.active,
  parameter int H_FP     = VGA640_H.fp,
  parameter int H_SYNC   = VGA640_H.sync,
  parameter int H_BP     = VGA640_H.bp,
  parameter int V_ACTIVE = VGA640_V.active,
  parameter int V_FP     = VGA640_V.fp,
  parameter int V_SYNC   = VGA640_V.sync,
  parameter int V_BP     = VGA640_V.bp,
  parameter bit H_POL    = VGA640_H.pol,
  parameter bit V_POL    = VGA640_V.pol
) (
  input  logic             clk_25MHz,
  input  logic             rst_n,
  input  logic             ce,
  input  logic             restart,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             line_end,
  output logic             frame_start
);

  localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  // line_end is registered, so it is raised while h_count sits one before the last pixel.
  localparam logic [CNT_W-1:0] H_PENULT = CNT_W'(H_TOTAL - 2);

  logic h_wrap, v_wrap;
  logic h_active_next, v_active_next;

  vga_axis_counter #(
    .CNT_W(CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .POL(H_POL)
  ) u_h_axis (
    .clk         (clk_25MHz),
    .rst_n       (rst_n),
    .advance     (ce),
    .restart     (restart),
    .count       (h_count),
    .sync        (hsync),
    .active_next (h_active_next),
    .wrap        (h_wrap)
  );

  vga_axis_counter #(
    .CNT_W(CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .POL(V_POL)
  ) u_v_axis (
    .clk         (clk_25MHz),
    .rst_n       (rst_n),
    .advance     (h_wrap),
    .restart     (restart),
    .count       (v_count),
    .sync        (vsync),
    .active_next (v_active_next),
    .wrap        (v_wrap)
  );

  // NOTE: only control flops are reset; there is no memory here that would need clearing.
  always_ff @(posedge clk_25MHz or negedge rst_n) begin
    if (!rst_n) begin
      video_on    <= 1'b1;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      video_on    <= h_active_next & v_active_next;
      line_end    <= ce & ~restart & (h_count == H_PENULT);
      frame_start <= restart | (h_wrap & v_wrap);
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480 build, a tiny raster for
// whole-frame checks, and an 800x600 positive-polarity build.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk_25MHz = 1'b0;
  logic rst_n     = 1'b0;
  logic ce        = 1'b0;
  logic restart   = 1'b0;

  always #20 clk_25MHz = ~clk_25MHz;

  logic [10:0] h_a, v_a;
  logic        hs_a, vs_a, vo_a, le_a, fs_a;
  logic [3:0]  h_s, v_s;
  logic        hs_s, vs_s, vo_s, le_s, fs_s;
  logic [10:0] h_w, v_w;
  logic        hs_w, vs_w, vo_w, le_w, fs_w;

  int checks = 0;
  int fails  = 0;

  vga_timing_gen dut_a (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .ce(ce), .restart(restart),
    .h_count(h_a), .v_count(v_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(vo_a), .line_end(le_a), .frame_start(fs_a)
  );

  // H: 8+2+3+2 = 15, V: 6+1+2+1 = 10 -> 150-cycle frame
  vga_timing_gen #(
    .CNT_W(4), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) dut_s (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .ce(ce), .restart(restart),
    .h_count(h_s), .v_count(v_s), .hsync(hs_s), .vsync(vs_s),
    .video_on(vo_s), .line_end(le_s), .frame_start(fs_s)
  );

  vga_timing_gen #(
    .CNT_W(11),
    .H_ACTIVE(VGA800_H.active), .H_FP(VGA800_H.fp), .H_SYNC(VGA800_H.sync), .H_BP(VGA800_H.bp),
    .V_ACTIVE(VGA800_V.active), .V_FP(VGA800_V.fp), .V_SYNC(VGA800_V.sync), .V_BP(VGA800_V.bp),
    .H_POL(VGA800_H.pol), .V_POL(VGA800_V.pol)
  ) dut_w (
    .clk_25MHz(clk_25MHz), .rst_n(rst_n), .ce(ce), .restart(restart),
    .h_count(h_w), .v_count(v_w), .hsync(hs_w), .vsync(vs_w),
    .video_on(vo_w), .line_end(le_w), .frame_start(fs_w)
  );

  logic [26:0] obs_a;
  logic [12:0] obs_s;
  logic [26:0] obs_w;
  assign obs_a = {h_a, v_a, hs_a, vs_a, vo_a, le_a, fs_a};
  assign obs_s = {h_s, v_s, hs_s, vs_s, vo_s, le_s, fs_s};
  assign obs_w = {h_w, v_w, hs_w, vs_w, vo_w, le_w, fs_w};

  // Expected default-build outputs at (h,v): 656..751 hsync low, 490..491 vsync low.
  function automatic logic [26:0] exp_a(int h, int v, bit le, bit fs);
    logic hs, vs, vo;
    hs = !(h >= 656 && h < 752);
    vs = !(v >= 490 && v < 492);
    vo = (h < 640) && (v < 480);
    return {11'(h), 11'(v), hs, vs, vo, le, fs};
  endfunction

  task automatic step();
    @(posedge clk_25MHz);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce = 1'b1; restart = 1'b0;
    repeat (3) step();
    checks++;
    if (obs_a !== exp_a(0, 0, 0, 0)) begin
      fails++; $display("FAIL reset_default: got %h expected %h", obs_a, exp_a(0, 0, 0, 0));
    end
    checks++;
    if ({hs_w, vs_w, vo_w, fs_w} !== 4'b0010) begin
      fails++; $display("FAIL reset_pos_pol: got %b expected 0010", {hs_w, vs_w, vo_w, fs_w});
    end
    ce = 1'b0; rst_n = 1'b1;
    step();
    checks++;
    if (obs_a !== exp_a(0, 0, 0, 0)) begin
      fails++; $display("FAIL release_hold: got %h expected %h", obs_a, exp_a(0, 0, 0, 0));
    end
    ce = 1'b1;
  endtask

  task automatic test_line();
    int hs_low = 0;
    for (int k = 1; k <= 801; k++) begin
      step();
      checks++;
      if (obs_a !== exp_a(k % 800, k / 800, (k % 800) == 799, 0)) begin
        fails++; $display("FAIL line_step k=%0d: got %h expected %h", k, obs_a,
                          exp_a(k % 800, k / 800, (k % 800) == 799, 0));
      end
      if (k <= 800 && !hs_a) hs_low++;
    end
    checks++;
    if (hs_low != 96) begin
      fails++; $display("FAIL hsync_width: got %0d expected 96", hs_low);
    end
    repeat (798) step();
    checks++;
    if (obs_a !== exp_a(799, 1, 1, 0)) begin
      fails++; $display("FAIL line_end_at_799: got %h expected %h", obs_a, exp_a(799, 1, 1, 0));
    end
  endtask

  task automatic test_ce_toggle();
    ce = 1'b0;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (obs_a !== exp_a(799, 1, 0, 0)) begin
        fails++; $display("FAIL ce_freeze %0d: got %h expected %h", k, obs_a, exp_a(799, 1, 0, 0));
      end
    end
    ce = 1'b1;
    step();
    checks++;
    if (obs_a !== exp_a(0, 2, 0, 0)) begin
      fails++; $display("FAIL ce_resume_wrap: got %h expected %h", obs_a, exp_a(0, 2, 0, 0));
    end
  endtask

  task automatic test_restart();
    repeat (300) step();
    checks++;
    if (obs_a !== exp_a(300, 2, 0, 0)) begin
      fails++; $display("FAIL pre_restart: got %h expected %h", obs_a, exp_a(300, 2, 0, 0));
    end
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (obs_a !== exp_a(0, 0, 0, 1)) begin
      fails++; $display("FAIL restart_origin: got %h expected %h", obs_a, exp_a(0, 0, 0, 1));
    end
    step();
    checks++;
    if (obs_a !== exp_a(1, 0, 0, 0)) begin
      fails++; $display("FAIL after_restart: got %h expected %h", obs_a, exp_a(1, 0, 0, 0));
    end
  endtask

  task automatic test_async_reset();
    repeat (699) step();
    checks++;
    if (obs_a !== exp_a(700, 0, 0, 0)) begin
      fails++; $display("FAIL mid_hsync: got %h expected %h", obs_a, exp_a(700, 0, 0, 0));
    end
    #10 rst_n = 1'b0;
    #2;
    checks++;
    if (obs_a !== exp_a(0, 0, 0, 0)) begin
      fails++; $display("FAIL async_reset: got %h expected %h", obs_a, exp_a(0, 0, 0, 0));
    end
    ce = 1'b0;
    #5 rst_n = 1'b1;
    step();
    checks++;
    if (obs_a !== exp_a(0, 0, 0, 0)) begin
      fails++; $display("FAIL post_reset_hold: got %h expected %h", obs_a, exp_a(0, 0, 0, 0));
    end
    ce = 1'b1;
    step();
    checks++;
    if (obs_a !== exp_a(1, 0, 0, 0)) begin
      fails++; $display("FAIL post_reset_first_ce: got %h expected %h", obs_a, exp_a(1, 0, 0, 0));
    end
  endtask

  task automatic test_frame_small();
    int fs_cnt = 0, vo_cnt = 0, vs_low = 0;
    int h, v;
    logic [12:0] exp;
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if (obs_s !== {4'd0, 4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1}) begin
      fails++; $display("FAIL small_restart: got %h expected %h", obs_s, 13'b0000000011101);
    end
    for (int k = 1; k <= 450; k++) begin
      step();
      h = k % 15;
      v = (k / 15) % 10;
      exp = {4'(h), 4'(v), !(h >= 10 && h < 13), !(v >= 7 && v < 9),
             (h < 8) && (v < 6), h == 14, (h == 0) && (v == 0)};
      checks++;
      if (obs_s !== exp) begin
        fails++; $display("FAIL small_step k=%0d: got %h expected %h", k, obs_s, exp);
      end
      if (fs_s) fs_cnt++;
      if (vo_s) vo_cnt++;
      if (!vs_s) vs_low++;
    end
    checks++;
    if (fs_cnt != 3) begin
      fails++; $display("FAIL frame_start_count: got %0d expected 3", fs_cnt);
    end
    checks++;
    if (vo_cnt != 144) begin
      fails++; $display("FAIL video_on_count: got %0d expected 144", vo_cnt);
    end
    checks++;
    if (vs_low != 90) begin
      fails++; $display("FAIL vsync_width: got %0d expected 90", vs_low);
    end
  endtask

  task automatic test_param_build();
    int hs_high = 0;
    int h, v;
    logic [26:0] exp;
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++;
    if ({h_w, v_w, fs_w, hs_w} !== {11'd0, 11'd0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL wide_restart: got %0d,%0d fs=%b hs=%b expected 0,0 fs=1 hs=0",
                        h_w, v_w, fs_w, hs_w);
    end
    for (int k = 1; k <= 1056; k++) begin
      step();
      h = k % 1056;
      v = k / 1056;
      exp = {11'(h), 11'(v), (h >= 840 && h < 968), 1'b0, h < 800, h == 1055, 1'b0};
      checks++;
      if (obs_w !== exp) begin
        fails++; $display("FAIL wide_step k=%0d: got %h expected %h", k, obs_w, exp);
      end
      if (hs_w) hs_high++;
    end
    checks++;
    if (hs_high != 128) begin
      fails++; $display("FAIL wide_hsync_width: got %0d expected 128", hs_high);
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_ce_toggle();
    test_restart();
    test_async_reset();
    test_frame_small();
    test_param_build();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised full-raster VGA timing generator; successor to the standalone horizontal counter.
- Horizontal and vertical counters are in one block, with a pixel-clock enable.
- Generates sync pulses with configurable polarity, an active-video flag, pixel coordinates and line/frame strobes.
- Sits between the pixel clock source and the pixel/colour pipeline driving the VGA connector.

Parameters:
- CNT_W, 11, width of both counters and coordinate outputs; must hold H_TOTAL-1 and V_TOTAL-1.
- H_ACTIVE, 640, visible pixels per line.
- H_FP, 16, horizontal front porch (pixels).
- H_SYNC, 96, hsync pulse width (pixels).
- H_BP, 48, horizontal back porch (pixels).
- V_ACTIVE, 480, visible lines per frame.
- V_FP, 10, vertical front porch (lines).
- V_SYNC, 2, vsync pulse width (lines).
- V_BP, 33, vertical back porch (lines).
- H_POL, 0, hsync asserted level (0 = active-low).
- V_POL, 0, vsync asserted level (0 = active-low).

Ports:
- clk_25MHz  in  1  pixel clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  pixel clock enable; counters advance only when 1.
- restart  in  1  synchronous request to jump to pixel (0,0).
- h_count  out  CNT_W  horizontal position, 0..H_TOTAL-1.
- v_count  out  CNT_W  vertical position, 0..V_TOTAL-1.
- hsync  out  1  horizontal sync, polarity H_POL.
- vsync  out  1  vertical sync, polarity V_POL.
- video_on  out  1  1 when h_count<H_ACTIVE and v_count<V_ACTIVE.
- line_end  out  1  one-cycle strobe on the last pixel of each line.
- frame_start  out  1  one-cycle strobe while at (0,0) after an advance or restart.

Behaviour:
- Derived constants: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800); V_TOTAL likewise (525).
- Reset (rst_n=0, asynchronous):
  - h_count=0, v_count=0.
  - hsync=~H_POL, vsync=~V_POL.
  - video_on=1, line_end=0, frame_start=0.
- Counters are 0-based and all outputs are registered. Every output is decoded from the next counter values, so in any cycle all outputs agree with h_count/v_count. No extra latency between coordinates and syncs.
- ce=1, restart=0:
  - If h_count==H_TOTAL-1: h_count wraps to 0. Then v_count wraps to 0 if it was V_TOTAL-1, else increments.
  - Otherwise h_count increments and v_count holds.
- ce=0, restart=0: all counters and decoded outputs hold. line_end and frame_start are forced to 0 (strobes last exactly one enabled advance).
- restart=1 has priority over ce: next h_count=0, v_count=0, frame_start=1, line_end=0, syncs deasserted.
- hsync asserted iff H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC (656..751 at defaults).
- vsync asserted iff V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC (490..491 at defaults).
- line_end=1 in the cycle where the registered h_count==H_TOTAL-1 was entered via ce=1.
- frame_start=1 in the cycle where (0,0) was entered via wrap or restart. It is not asserted out of reset.
- Widths: comparisons are unsigned at CNT_W. An elaboration check fails if H_TOTAL>2^CNT_W, V_TOTAL>2^CNT_W, or any timing parameter is 0.
- Reset mid-frame: immediate return to reset values; counting resumes from (0,0) on the first ce after release.

Decomposition:
- Shared package vga_timing_pkg holds:
  - localparam sets for standard modes (640x480@60, 800x600@60);
  - function calc_total(active, fp, sync, bp).
- One natural sub-module, vga_axis_counter, instantiated twice (horizontal and vertical). It contains the counter, wrap detection, and sync/active decoding per axis, with parameters ACTIVE/FP/SYNC/BP/POL. It has an advance input and emits a wrap output; the horizontal wrap drives the vertical advance.

Test Plan:
- Reset release, ce=1 steady: h_count 0..799 then 0; line_end high exactly when h_count=799; v_count increments to 1 when h_count returns to 0.
- Sync windows at defaults: hsync low for h_count 656..751 only (96 cycles); vsync low for v_count 490..491 only (1600 cycles).
- Full frame, 420000 enabled cycles: frame_start pulses once per frame at (0,0); video_on count per frame = 307200.
- ce toggled 1,0,0,1 at h_count=799: outputs frozen during ce=0 with line_end=0; wrap to 0 only on the next ce=1.
- restart asserted at (300,200) with ce=1: next cycle (0,0), frame_start=1; normal counting continues.
- Async reset asserted mid-hsync (h_count=700): outputs return to reset values without a clock edge. Plus an H_POL=1, V_POL=1, 800x600 parameter build: hsync high 840..967, H_TOTAL 1056.
